// File: rtl/soc_mem_pkg.sv
// Shared types for the three-port memory arbiter: port indices and the
// one-deep response register carried from the grant cycle to the rvalid cycle.
package soc_mem_pkg;

    typedef enum logic [1:0] {
        PORT_INSTR = 2'd0,
        PORT_DATA  = 2'd1,
        PORT_VPU   = 2'd2
    } port_e;

    // Ceiling on the coprocessor id width stored in the response register.
    localparam int unsigned MAX_ID_W = 16;

    typedef struct packed {
        logic                valid;
        logic                rd;
        logic                err;
        port_e               port;
        logic [MAX_ID_W-1:0] id;
    } rsp_t;

    function automatic port_e next_port(input port_e p);
        return (p == PORT_VPU) ? PORT_INSTR : port_e'(p + 2'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin picker: search starts one past the last winner and
// returns a one-hot grant (all zero when nothing requests).
module rr_arbiter3
    import soc_mem_pkg::*;
(
    input  logic [2:0] req_i,
    input  port_e      last_i,
    output logic [2:0] gnt_o
);

    port_e p;

    always_comb begin
        gnt_o = '0;
        p     = next_port(last_i);
        for (int k = 0; k < 3; k++) begin
            if (req_i[p] && (gnt_o == 3'b000)) begin
                gnt_o[p] = 1'b1;
            end
            p = next_port(p);
        end
    end

endmodule

// File: rtl/soc_mem_arbiter.sv
// Single-port SRAM arbiter for CPU fetch, CPU load/store and VPU ports:
// one grant per cycle, round-robin, fixed one-cycle response.
module soc_mem_arbiter
    import soc_mem_pkg::*;
#(
    parameter int X_ID_WIDTH = 4,
    parameter int MEM_WORDS  = 8192
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    output logic                         instr_err_o,

    input  logic                         data_req_i,
    input  logic                         data_we_i,
    input  logic [3:0]                   data_be_i,
    input  logic [31:0]                  data_addr_i,
    input  logic [31:0]                  data_wdata_i,
    output logic                         data_gnt_o,
    output logic                         data_rvalid_o,
    output logic [31:0]                  data_rdata_o,
    output logic                         data_err_o,

    input  logic                         vpu_req_i,
    input  logic                         vpu_we_i,
    input  logic [3:0]                   vpu_be_i,
    input  logic [31:0]                  vpu_addr_i,
    input  logic [31:0]                  vpu_wdata_i,
    input  logic [X_ID_WIDTH-1:0]        vpu_id_i,
    output logic                         vpu_gnt_o,
    output logic                         vpu_rvalid_o,
    output logic [31:0]                  vpu_rdata_o,
    output logic [X_ID_WIDTH-1:0]        vpu_rid_o,
    output logic                         vpu_err_o,

    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [3:0]                   mem_be_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    output logic [31:0]                  mem_wdata_o,
    input  logic [31:0]                  mem_rdata_i
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [2:0]  req, gnt_raw, gnt;
    port_e       last_q, last_d, sel_port;
    rsp_t        rsp_q, rsp_d;
    logic        sel_we, in_range, rsp_live;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr, sel_wdata, rd_data;

    assign req = {vpu_req_i, data_req_i, instr_req_i};

    rr_arbiter3 u_rr (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (gnt_raw)
    );

    always_comb begin
        gnt       = rst_i ? 3'b000 : gnt_raw;
        sel_port  = PORT_INSTR;
        sel_we    = 1'b0;
        sel_be    = 4'hF;
        sel_addr  = instr_addr_i;
        sel_wdata = '0;
        if (gnt[PORT_DATA]) begin
            sel_port  = PORT_DATA;
            sel_we    = data_we_i;
            sel_be    = data_be_i;
            sel_addr  = data_addr_i;
            sel_wdata = data_wdata_i;
        end else if (gnt[PORT_VPU]) begin
            sel_port  = PORT_VPU;
            sel_we    = vpu_we_i;
            sel_be    = vpu_be_i;
            sel_addr  = vpu_addr_i;
            sel_wdata = vpu_wdata_i;
        end
        in_range = ({2'b00, sel_addr[31:2]} < 32'(MEM_WORDS));

        mem_req_o   = (|gnt) & in_range;
        mem_we_o    = mem_req_o & sel_we;
        mem_be_o    = sel_be;
        mem_addr_o  = sel_addr[AW+1:2];
        mem_wdata_o = sel_wdata;

        last_d = last_q;
        rsp_d  = '0;
        if (|gnt) begin
            last_d      = sel_port;
            rsp_d.valid = 1'b1;
            rsp_d.rd    = ~sel_we;
            rsp_d.err   = ~in_range;
            rsp_d.port  = sel_port;
            rsp_d.id    = gnt[PORT_VPU] ? MAX_ID_W'(vpu_id_i) : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= PORT_VPU;
            rsp_q  <= '0;
        end else begin
            last_q <= last_d;
            rsp_q  <= rsp_d;
        end
    end

    assign instr_gnt_o = gnt[PORT_INSTR];
    assign data_gnt_o  = gnt[PORT_DATA];
    assign vpu_gnt_o   = gnt[PORT_VPU];

    // Response is squashed while reset is held so a grant just before reset never surfaces.
    assign rsp_live = rsp_q.valid & ~rst_i;
    assign rd_data  = (rsp_q.rd && !rsp_q.err) ? mem_rdata_i : '0;

    assign instr_rvalid_o = rsp_live && (rsp_q.port == PORT_INSTR);
    assign data_rvalid_o  = rsp_live && (rsp_q.port == PORT_DATA);
    assign vpu_rvalid_o   = rsp_live && (rsp_q.port == PORT_VPU);

    assign instr_err_o   = instr_rvalid_o & rsp_q.err;
    assign data_err_o    = data_rvalid_o & rsp_q.err;
    assign vpu_err_o     = vpu_rvalid_o & rsp_q.err;
    assign instr_rdata_o = instr_rvalid_o ? rd_data : '0;
    assign data_rdata_o  = data_rvalid_o ? rd_data : '0;
    assign vpu_rdata_o   = vpu_rvalid_o ? rd_data : '0;
    assign vpu_rid_o     = vpu_rvalid_o ? rsp_q.id[X_ID_WIDTH-1:0] : '0;

    logic unused_ok;
    assign unused_ok = ^{sel_addr[1:0], sel_addr[31:AW+2], rsp_q.id};

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Bench for soc_mem_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of grants, memory and responses.
module tb_soc_mem_arbiter;

    localparam int IDW   = 4;
    localparam int WORDS = 8192;
    localparam int AW    = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0]     instr_addr_i, instr_rdata_o;
    logic            data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
    logic [3:0]      data_be_i;
    logic [31:0]     data_addr_i, data_wdata_i, data_rdata_o;
    logic            vpu_req_i, vpu_we_i, vpu_gnt_o, vpu_rvalid_o, vpu_err_o;
    logic [3:0]      vpu_be_i;
    logic [31:0]     vpu_addr_i, vpu_wdata_i, vpu_rdata_o;
    logic [IDW-1:0]  vpu_id_i, vpu_rid_o;
    logic            mem_req_o, mem_we_o;
    logic [3:0]      mem_be_o;
    logic [AW-1:0]   mem_addr_o;
    logic [31:0]     mem_wdata_o, mem_rdata_i;

    soc_mem_arbiter #(.X_ID_WIDTH(IDW), .MEM_WORDS(WORDS)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .vpu_req_i(vpu_req_i), .vpu_we_i(vpu_we_i), .vpu_be_i(vpu_be_i),
        .vpu_addr_i(vpu_addr_i), .vpu_wdata_i(vpu_wdata_i), .vpu_id_i(vpu_id_i),
        .vpu_gnt_o(vpu_gnt_o), .vpu_rvalid_o(vpu_rvalid_o), .vpu_rdata_o(vpu_rdata_o),
        .vpu_rid_o(vpu_rid_o), .vpu_err_o(vpu_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // SRAM: byte-enabled write, registered read data.
    logic [31:0] sram [WORDS];
    logic [31:0] sram_q;
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                sram_q <= sram[mem_addr_o];
            end
        end
    end
    assign mem_rdata_i = sram_q;

    // Reference model state
    logic [31:0]    ref_mem [WORDS];
    bit   [3:0]     known   [WORDS];
    int             m_last;
    bit             exp_v, exp_err, exp_chk;
    int             exp_port;
    logic [31:0]    exp_rdata;
    logic [IDW-1:0] exp_id;
    int             errors = 0;
    int             checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return a[31:2] < 30'(WORDS);
    endfunction

    // One clock: check the cycle at negedge, advance the model, return at posedge+1.
    task automatic step(output int win);
        bit          rq [3];
        logic [31:0] ad [3];
        bit          wr [3];
        logic [3:0]  be [3];
        logic [31:0] wd [3];
        logic [31:0] o_rd;
        logic        o_er;
        int          p, word;
        bit          mreq;
        @(negedge clk);
        rq = '{instr_req_i, data_req_i, vpu_req_i};
        ad = '{instr_addr_i, data_addr_i, vpu_addr_i};
        wr = '{1'b0, data_we_i, vpu_we_i};
        be = '{4'hF, data_be_i, vpu_be_i};
        wd = '{32'h0, data_wdata_i, vpu_wdata_i};
        win = -1;
        if (rst) begin
            chk("rst_gnt", {instr_gnt_o, data_gnt_o, vpu_gnt_o}, 0);
            chk("rst_rvalid", {instr_rvalid_o, data_rvalid_o, vpu_rvalid_o}, 0);
            chk("rst_err", {instr_err_o, data_err_o, vpu_err_o}, 0);
            chk("rst_mem_req", mem_req_o, 0);
            chk("rst_rdata", instr_rdata_o | data_rdata_o | vpu_rdata_o, 0);
            chk("rst_rid", vpu_rid_o, 0);
            m_last = 2;
            exp_v  = 0;
        end else begin
            for (int k = 1; k <= 3; k++) begin
                p = (m_last + k) % 3;
                if (rq[p] && win < 0) win = p;
            end
            chk("instr_gnt", instr_gnt_o, 32'(win == 0));
            chk("data_gnt", data_gnt_o, 32'(win == 1));
            chk("vpu_gnt", vpu_gnt_o, 32'(win == 2));
            mreq = (win >= 0) && in_rng(ad[win]);
            chk("mem_req", mem_req_o, 32'(mreq));
            if (mreq) begin
                chk("mem_addr", mem_addr_o, ad[win][AW+1:2]);
                chk("mem_we", mem_we_o, 32'(wr[win]));
                if (wr[win]) begin
                    chk("mem_be", mem_be_o, be[win]);
                    chk("mem_wdata", mem_wdata_o, wd[win]);
                end
            end
            chk("instr_rvalid", instr_rvalid_o, 32'(exp_v && exp_port == 0));
            chk("data_rvalid", data_rvalid_o, 32'(exp_v && exp_port == 1));
            chk("vpu_rvalid", vpu_rvalid_o, 32'(exp_v && exp_port == 2));
            if (exp_v) begin
                case (exp_port)
                    0:       begin o_rd = instr_rdata_o; o_er = instr_err_o; end
                    1:       begin o_rd = data_rdata_o;  o_er = data_err_o;  end
                    default: begin o_rd = vpu_rdata_o;   o_er = vpu_err_o;   end
                endcase
                chk("rsp_err", o_er, 32'(exp_err));
                if (exp_chk) chk("rsp_rdata", o_rd, exp_rdata);
                if (exp_port == 2) chk("vpu_rid", vpu_rid_o, exp_id);
            end
            if (win >= 0) begin
                m_last   = win;
                exp_v    = 1;
                exp_port = win;
                exp_err  = !in_rng(ad[win]);
                exp_id   = (win == 2) ? vpu_id_i : '0;
                word     = int'(ad[win][AW+1:2]);
                exp_chk  = 1;
                exp_rdata = 32'h0;
                if (!exp_err) begin
                    if (wr[win]) begin
                        for (int b = 0; b < 4; b++)
                            if (be[win][b]) begin
                                ref_mem[word][8*b +: 8] = wd[win][8*b +: 8];
                                known[word][b] = 1'b1;
                            end
                    end else begin
                        exp_rdata = ref_mem[word];
                        exp_chk   = (known[word] == 4'hF);
                    end
                end
            end else begin
                exp_v = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_req_i = 0; data_req_i = 0; vpu_req_i = 0;
    endtask

    task automatic drv_data(input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        data_req_i = 1; data_we_i = we; data_be_i = be; data_addr_i = a; data_wdata_i = d;
    endtask

    task automatic drv_vpu(input bit we, input logic [3:0] be, input logic [31:0] a,
                           input logic [31:0] d, input logic [IDW-1:0] id);
        vpu_req_i = 1; vpu_we_i = we; vpu_be_i = be; vpu_addr_i = a; vpu_wdata_i = d; vpu_id_i = id;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 6)      return 32'($urandom_range(0, 15)) << 2;
        else if (sel == 7) return 32'(WORDS - 1) << 2;
        else if (sel == 8) return 32'(WORDS) << 2;
        else               return 32'h0001_0000 | (32'($urandom_range(0, 255)) << 2);
    endfunction

    initial begin
        int w;
        for (int i = 0; i < WORDS; i++) begin
            ref_mem[i] = '0;
            known[i]   = '0;
        end
        m_last = 2; exp_v = 0; exp_port = 0; exp_err = 0; exp_chk = 0;
        exp_rdata = '0; exp_id = '0;
        rst = 1;
        idle();
        instr_addr_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
        vpu_we_i = 0; vpu_be_i = 0; vpu_addr_i = 0; vpu_wdata_i = 0; vpu_id_i = 0;
        step(w);
        step(w);
        rst = 0;

        // All three held from reset: instr, data, vpu, instr.
        instr_req_i = 1; instr_addr_i = 32'h0;
        drv_data(0, 4'hF, 32'h4, 0);
        drv_vpu(0, 4'hF, 32'h8, 0, 4'd1);
        for (int i = 0; i < 4; i++) begin
            step(w);
            chk("rr_order", w, i % 3);
        end
        idle();
        step(w);
        chk("idle_no_grant", w, -1);

        // VPU write then data read of the same word.
        drv_vpu(1, 4'hF, 32'h100, 32'hDEADBEEF, 4'd3);
        step(w);
        idle();
        chk("vpu_wr_rvalid", vpu_rvalid_o, 1);
        chk("vpu_wr_rid", vpu_rid_o, 3);
        chk("vpu_wr_err", vpu_err_o, 0);
        drv_data(0, 4'hF, 32'h100, 0);
        step(w);
        idle();
        chk("data_rd_rdata", data_rdata_o, 32'hDEADBEEF);

        // Byte-lane merge.
        drv_data(1, 4'hF, 32'h104, 32'h11223344);
        step(w);
        drv_data(1, 4'b0010, 32'h104, 32'h0000AB00);
        step(w);
        drv_data(0, 4'hF, 32'h104, 0);
        step(w);
        idle();
        chk("be_merge", data_rdata_o, 32'h1122AB44);

        // Out-of-range VPU read.
        drv_vpu(0, 4'hF, 32'h0001_0000, 0, 4'd5);
        #1;
        chk("oor_gnt", vpu_gnt_o, 1);
        chk("oor_mem_req", mem_req_o, 0);
        step(w);
        idle();
        chk("oor_rvalid", vpu_rvalid_o, 1);
        chk("oor_err", vpu_err_o, 1);
        chk("oor_rdata", vpu_rdata_o, 0);

        // data and vpu both saturated: strict alternation starting with data.
        drv_data(0, 4'hF, 32'h0, 0);
        drv_vpu(0, 4'hF, 32'h4, 0, 4'd7);
        for (int i = 0; i < 8; i++) begin
            step(w);
            chk("alternate", w, (i % 2 == 0) ? 1 : 2);
        end
        idle();

        // Reset right after an instr grant drops the response and restores the pointer.
        instr_req_i = 1; instr_addr_i = 32'h0;
        step(w);
        chk("pre_rst_gnt", w, 0);
        instr_req_i = 0;
        rst = 1;
        step(w);
        rst = 0;
        step(w);
        chk("post_rst_no_rvalid", instr_rvalid_o, 0);
        instr_req_i = 1;
        drv_data(0, 4'hF, 32'h0, 0);
        drv_vpu(0, 4'hF, 32'h0, 0, 4'd2);
        step(w);
        chk("post_rst_first", w, 0);
        idle();

        // Random traffic with requesters that hold until granted.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            step(w);
            if (w == 0) instr_req_i = 0;
            if (w == 1) data_req_i = 0;
            if (w == 2) vpu_req_i = 0;
            if (!instr_req_i && $urandom_range(0, 9) < 6) begin
                instr_req_i = 1; instr_addr_i = rand_addr();
            end
            if (!data_req_i && $urandom_range(0, 9) < 6)
                drv_data(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(), $urandom);
            if (!vpu_req_i && $urandom_range(0, 9) < 6)
                drv_vpu(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(),
                        $urandom, IDW'($urandom_range(0, 15)));
        end
        rst = 0;
        idle();
        step(w);
        step(w);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/soc_mem_arbiter.md
SOC_MEM_ARBITER -- requirements
Module: soc_mem_arbiter

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4, width of the VPU transaction id.
REQ-002 SHALL have parameter MEM_WORDS, default 8192, number of 32-bit words in main memory (32KB).
REQ-003 clk_i  in  1  single clock; all logic on posedge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 instr_req_i / instr_addr_i  in  1 / 32  CPU fetch request (read-only port).
REQ-006 instr_gnt_o / instr_rvalid_o / instr_rdata_o / instr_err_o  out  1 / 1 / 32 / 1  fetch grant and response.
REQ-007 data_req_i / data_we_i / data_be_i / data_addr_i / data_wdata_i  in  1 / 1 / 4 / 32 / 32  CPU load/store request.
REQ-008 data_gnt_o / data_rvalid_o / data_rdata_o / data_err_o  out  1 / 1 / 32 / 1  load/store grant and response.
REQ-009 vpu_req_i / vpu_we_i / vpu_be_i / vpu_addr_i / vpu_wdata_i / vpu_id_i  in  1 / 1 / 4 / 32 / 32 / X_ID_WIDTH  coprocessor memory request.
REQ-010 vpu_gnt_o / vpu_rvalid_o / vpu_rdata_o / vpu_rid_o / vpu_err_o  out  1 / 1 / 32 / X_ID_WIDTH / 1  coprocessor grant and result.
REQ-011 mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  out  1 / 1 / 4 / $clog2(MEM_WORDS) / 32  single-port SRAM command (word address).
REQ-012 mem_rdata_i  in  32  SRAM read data, valid the cycle after mem_req_o.

Function
REQ-013 Port indices: 0 = instr, 1 = data, 2 = vpu; instr port always behaves as we=0, be=4'hF.
REQ-014 At most one gnt_o SHALL be asserted per cycle; gnt_o is combinational from req_i and the round-robin pointer.
REQ-015 Priority order SHALL start at (last_winner+1) mod 3; last_winner updates on every grant.
REQ-016 A requesting port that is not granted SHALL be granted within 2 further cycles (no starvation).
REQ-017 Requester holds req/addr/we/be/wdata/id stable until gnt; arbiter never relies on values after grant cycle.
REQ-018 In range (addr[31:2] < MEM_WORDS): mem_req_o=1 in grant cycle, mem_addr_o=addr[31:2], we/be/wdata forwarded.
REQ-019 Out of range: grant still given, mem_req_o=0, response err=1, rdata=0.
REQ-020 Response latency exactly 1 cycle: granted port's rvalid_o=1 in cycle after gnt, for reads and writes.
REQ-021 rdata_o = mem_rdata_i on in-range reads; 0 for writes and errors; vpu_rid_o = id captured at grant.
REQ-022 Back-to-back grants (one per cycle, any mix of ports) SHALL sustain full throughput.
REQ-023 No req_i asserted: all gnt_o=0, mem_req_o=0, pointer unchanged.
REQ-024 Write then read same address in consecutive cycles SHALL return new data (SRAM write-first not required; arbiter adds no forwarding, read issues after write cycle).

Reset
REQ-025 On rst_i: all gnt_o/rvalid_o/err_o/mem_req_o = 0, rdata/rid = 0, last_winner = 2 (instr first).
REQ-026 Reset mid-transaction SHALL drop any pending response; no rvalid after reset deasserts without new grant.

Structure
REQ-027 Port index enum and response-register struct (port, err, id) SHALL live in shared package soc_mem_pkg.
REQ-028 Round-robin selection SHALL be sub-module rr_arbiter3 (req[2:0], last, gnt onehot); remainder is muxing and response register.

Verification
REQ-029 All three req from reset, held -> grants in order instr, data, vpu, instr, one per cycle; rvalids follow by 1 cycle.
REQ-030 vpu write addr 0x100 data 0xDEADBEEF be 4'hF id 3, then data read 0x100 -> vpu_rvalid rid=3 err=0; data_rdata=0xDEADBEEF.
REQ-031 data write 0x104 be 4'b0010 wdata 0x0000AB00 over 0x11223344 -> read returns 0x1122AB44.
REQ-032 vpu read addr 0x0001_0000 -> vpu_gnt=1, mem_req_o=0, next cycle vpu_rvalid=1 err=1 rdata=0.
REQ-033 data and vpu continuously requesting -> strict alternation, no gap, neither waits > 2 cycles.
REQ-034 Assert rst_i the cycle after instr grant -> instr_rvalid never asserts; first grant after release goes to instr.
